// File: rtl/rv_imm_pkg.sv
// Shared definitions for the RISC-V immediate generator: format select
// encoding, default immediate width and a queue sizing helper.
package rv_imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    SEL_NONE = 3'b000,
    SEL_I    = 3'b001,
    SEL_U    = 3'b010,
    SEL_S    = 3'b011,
    SEL_B    = 3'b100,
    SEL_J    = 3'b101,
    SEL_Z    = 3'b110,
    SEL_SH   = 3'b111
  } sel_e;

  // Occupancy needs one bit more than a pointer so that "full" is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/result handshake bundle of imm_gen_pipe; the slave side is the
// generator, the master side is whoever issues requests and consumes results.
interface imm_gen_pipe_if #(
  parameter int XLEN  = rv_imm_pkg::XLEN_DEFAULT,
  parameter int DEPTH = 2
) ();

  logic                        valid_i;
  logic                        ready_o;
  logic [31:0]                 instr_i;
  rv_imm_pkg::sel_e            sel_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [XLEN-1:0]             imm_o;
  logic                        illegal_o;
  logic [$clog2(DEPTH):0]      count_o;

  modport slave (
    input  valid_i, instr_i, sel_i, ready_i,
    output ready_o, valid_o, imm_o, illegal_o, count_o
  );

  modport master (
    output valid_i, instr_i, sel_i, ready_i,
    input  ready_o, valid_o, imm_o, illegal_o, count_o
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction: builds a 32-bit signed immediate for the
// selected format, then sign-extends it to XLEN in one place.
module imm_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]             instr,
  input  sel_e                    sel,
  output logic signed [XLEN-1:0]  imm,
  output logic                    illegal
);

  logic signed [31:0] val;

  // Zero-extended formats keep bit 31 clear, so the final signed widening is safe for all.
  always_comb begin
    val     = '0;
    illegal = 1'b0;
    case (sel)
      SEL_NONE: illegal = 1'b1;
      SEL_I:    val = 32'($signed(instr[31:20]));
      SEL_U:    val = $signed({instr[31:12], 12'h000});
      SEL_S:    val = 32'($signed({instr[31:25], instr[11:7]}));
      SEL_B:    val = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      SEL_J:    val = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      SEL_Z:    val = $signed({27'd0, instr[19:15]});
      SEL_SH: begin
        if (XLEN == 32) begin
          val     = $signed({27'd0, instr[24:20]});
          illegal = instr[25];
        end else begin
          val     = $signed({26'd0, instr[25:20]});
        end
      end
    endcase
  end

  assign imm = XLEN'(val);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry in-order result queue; the head entry
// is mirrored in a reset register that drives the result outputs directly.
module imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  imm_gen_pipe_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0]          count;
  logic [PW-1:0]          wptr;
  logic [PW-1:0]          rptr;
  logic [PW-1:0]          rptr_inc;
  logic                   ready;
  logic                   valid;
  logic                   push;
  logic                   pop;

  logic signed [XLEN-1:0] mem_imm [DEPTH];
  logic                   mem_ill [DEPTH];

  logic signed [XLEN-1:0] dec_imm_p0;
  logic                   dec_ill_p0;
  logic signed [XLEN-1:0] head_imm_p1;
  logic                   head_ill_p1;

  // Handshake is decoded from registered occupancy only, never from ready_i.
  assign ready    = (count < CW'(DEPTH));
  assign valid    = (count != '0);
  assign push     = bus.valid_i && ready;
  assign pop      = valid && bus.ready_i;
  assign rptr_inc = rptr + PW'(1);

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr   (bus.instr_i),
    .sel     (bus.sel_i),
    .imm     (dec_imm_p0),
    .illegal (dec_ill_p0)
  );

  // ---- p0 -> p1: decoded request enters queue storage ----
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_imm[wptr] <= dec_imm_p0;
      mem_ill[wptr] <= dec_ill_p0;
    end
  end

  // The new head is the incoming request when the queue is (or becomes) empty,
  // otherwise the stored entry behind the one being popped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      head_imm_p1 <= '0;
      head_ill_p1 <= 1'b0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr_inc;
      if (push && (count == CW'(pop))) begin
        head_imm_p1 <= dec_imm_p0;
        head_ill_p1 <= dec_ill_p0;
      end else if (pop && (count > CW'(1))) begin
        head_imm_p1 <= mem_imm[rptr_inc];
        head_ill_p1 <= mem_ill[rptr_inc];
      end
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid;
  assign bus.imm_o     = head_imm_p1;
  assign bus.illegal_o = head_ill_p1;
  assign bus.count_o   = count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance, both
// DEPTH=2, fed identical stimulus and checked against hand-derived values.
module tb_imm_gen_pipe;
  import rv_imm_pkg::*;

  logic clk;
  logic rst_ni;
  int   n_cmp;
  int   n_bad;

  imm_gen_pipe_if #(.XLEN(32), .DEPTH(2)) if32 ();
  imm_gen_pipe_if #(.XLEN(64), .DEPTH(2)) if64 ();

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (if32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u_dut64 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input sel_e s, input logic [31:0] ins, input logic r);
    if32.valid_i = v;  if32.sel_i = s;  if32.instr_i = ins;  if32.ready_i = r;
    if64.valid_i = v;  if64.sel_i = s;  if64.instr_i = ins;  if64.ready_i = r;
  endtask

  function automatic logic [31:0] addi(input logic [11:0] k);
    return {k, 20'h00013};
  endfunction

  // Accept one request into an empty queue, check it next cycle, then drain it.
  task automatic one(input string tag, input sel_e s, input logic [31:0] ins,
                     input logic [31:0] e32, input logic il32,
                     input logic [63:0] e64, input logic il64);
    drive(1'b1, s, ins, 1'b1);
    step();
    chk({tag, "_vld32"}, 64'(if32.valid_o), 64'd1);
    chk({tag, "_imm32"}, 64'(if32.imm_o), 64'(e32));
    chk({tag, "_ill32"}, 64'(if32.illegal_o), 64'(il32));
    chk({tag, "_cnt32"}, 64'(if32.count_o), 64'd1);
    chk({tag, "_vld64"}, 64'(if64.valid_o), 64'd1);
    chk({tag, "_imm64"}, if64.imm_o, e64);
    chk({tag, "_ill64"}, 64'(if64.illegal_o), 64'(il64));
    drive(1'b0, SEL_NONE, 32'h0, 1'b1);
    step();
    chk({tag, "_drain32"}, 64'(if32.valid_o), 64'd0);
    chk({tag, "_drain64"}, 64'(if64.valid_o), 64'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_ni = 1'b0;
    drive(1'b0, SEL_NONE, 32'h0, 1'b0);
    step();
    step();
    chk("rst_vld32", 64'(if32.valid_o), 64'd0);
    chk("rst_cnt32", 64'(if32.count_o), 64'd0);
    chk("rst_rdy32", 64'(if32.ready_o), 64'd1);
    chk("rst_imm32", 64'(if32.imm_o), 64'd0);
    chk("rst_ill32", 64'(if32.illegal_o), 64'd0);
    chk("rst_imm64", if64.imm_o, 64'd0);
    rst_ni = 1'b1;
    step();

    // Format decode, single request at a time
    one("i_neg",   SEL_I,    32'hFFF00093, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    one("u_neg",   SEL_U,    32'h800002B7, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
    one("u_pos",   SEL_U,    32'h12345037, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0);
    one("b_neg",   SEL_B,    32'hFE000EE3, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    one("s_neg",   SEL_S,    32'hFE000E23, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    one("j_pos",   SEL_J,    32'h0080006F, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0);
    one("j_neg",   SEL_J,    32'hFFDFF06F, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    one("z_max",   SEL_Z,    32'hFFFF8000, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
    one("sh_b25",  SEL_SH,   32'h02051513, 32'h00000000, 1'b1, 64'h0000000000000020, 1'b0);
    one("sh_ok",   SEL_SH,   32'h01F00013, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
    one("none",    SEL_NONE, 32'hFFFFFFFF, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1);

    // Back-pressure: three requests offered, only two fit
    drive(1'b1, SEL_I, addi(12'd1), 1'b0);
    step();
    chk("bp_cnt1", 64'(if32.count_o), 64'd1);
    chk("bp_rdy1", 64'(if32.ready_o), 64'd1);
    drive(1'b1, SEL_I, addi(12'd2), 1'b0);
    step();
    chk("bp_cnt2", 64'(if32.count_o), 64'd2);
    chk("bp_rdy2", 64'(if32.ready_o), 64'd0);
    drive(1'b1, SEL_I, addi(12'd3), 1'b0);
    step();
    chk("bp_cnt3", 64'(if32.count_o), 64'd2);
    chk("bp_head", 64'(if32.imm_o), 64'd1);
    chk("bp_cnt64", 64'(if64.count_o), 64'd2);
    drive(1'b0, SEL_NONE, 32'h0, 1'b1);
    step();
    chk("bp_out2", 64'(if32.imm_o), 64'd2);
    chk("bp_out2_64", if64.imm_o, 64'd2);
    chk("bp_cnt_d1", 64'(if32.count_o), 64'd1);
    step();
    chk("bp_empty", 64'(if32.valid_o), 64'd0);
    step();
    chk("bp_noextra", 64'(if32.valid_o), 64'd0);

    // Full queue streaming with ready_i held: first cycle only drains, then one in/one out
    drive(1'b1, SEL_I, addi(12'd16), 1'b0);
    step();
    drive(1'b1, SEL_I, addi(12'd17), 1'b0);
    step();
    chk("fl_cnt", 64'(if32.count_o), 64'd2);
    chk("fl_rdy", 64'(if32.ready_o), 64'd0);
    drive(1'b1, SEL_I, addi(12'd18), 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("st%0d_vld", i), 64'(if32.valid_o), 64'd1);
      chk($sformatf("st%0d_imm32", i), 64'(if32.imm_o), 64'(17 + i));
      chk($sformatf("st%0d_imm64", i), if64.imm_o, 64'(17 + i));
      chk($sformatf("st%0d_cnt", i), 64'(if32.count_o), 64'd1);
      drive(1'b1, SEL_I, addi(12'(18 + i)), 1'b1);
    end
    drive(1'b0, SEL_NONE, 32'h0, 1'b1);
    step();
    chk("st_drain", 64'(if32.valid_o), 64'd0);

    // Asynchronous reset with a full queue
    drive(1'b1, SEL_I, addi(12'd48), 1'b0);
    step();
    drive(1'b1, SEL_I, addi(12'd49), 1'b0);
    step();
    drive(1'b0, SEL_NONE, 32'h0, 1'b0);
    chk("ar_full", 64'(if32.count_o), 64'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_vld32", 64'(if32.valid_o), 64'd0);
    chk("ar_cnt32", 64'(if32.count_o), 64'd0);
    chk("ar_rdy32", 64'(if32.ready_o), 64'd1);
    chk("ar_imm32", 64'(if32.imm_o), 64'd0);
    chk("ar_cnt64", 64'(if64.count_o), 64'd0);
    step();
    rst_ni = 1'b1;
    drive(1'b0, SEL_NONE, 32'h0, 1'b1);
    step();
    chk("ar_stale1", 64'(if32.valid_o), 64'd0);
    step();
    chk("ar_stale2", 64'(if32.valid_o), 64'd0);
    chk("ar_stale64", 64'(if64.valid_o), 64'd0);

    one("post_rst", SEL_I, addi(12'd5), 32'h00000005, 1'b0, 64'h0000000000000005, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
